pwm_actuator: RTL and testbench
===============================

Name: pwm_actuator

Overview:
- Output stage directly downstream of the PID controller: consumes its 16-bit two's-complement control word and drives a sign/magnitude H-bridge interface (pwm_out + dir_out).
- Double-buffers the control word: pending register, transferred to the active register only at a PWM period boundary.
- Clamps the magnitude to MAX_DUTY and inserts a dead-time gap whenever the direction reverses.

Parameters:
- PERIOD, 1000: clock cycles per PWM period (>=2, <=65535).
- MAX_DUTY, 1000: magnitude clamp in cycles (<=PERIOD). MAX_DUTY == PERIOD allows 100% duty.
- DEADTIME, 16: idle cycles (>=1) inserted before a direction change takes effect.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  run request; low forces IDLE.
- duty_in  in  16  signed control word, two's complement (PID output).
- duty_valid  in  1  single-cycle strobe; samples duty_in into pending.
- pwm_out  out  1  registered PWM drive.
- dir_out  out  1  registered direction (1 = negative duty_in).
- period_start  out  1  registered; high in the first RUN cycle of every period.
- sat_flag  out  1  registered; high while the active magnitude is clamped.

Behaviour:
- Reset (async): state=IDLE, cnt=0, dead counter=0, pending=0, active mag=0. All outputs 0.
- Conversion: sign = duty_in[15]; mag = |duty_in| using a 17-bit intermediate, so -32768 gives 32768.
  - If mag > MAX_DUTY: mag = MAX_DUTY and sat = 1.
  - Conversion is applied on sampling; pending holds {sign, mag, sat}.
- Pending: loaded on any edge with duty_valid=1, in any state.
- Transfer source: on a transfer edge, if duty_valid=1 in that same cycle, the transfer takes the new duty_in (bypass); otherwise it takes pending.
- States:
  - IDLE: cnt=0; pwm_out=0; period_start=0. dir_out and sat_flag hold.
    - enable=1 -> transfer edge (see below).
  - RUN: cnt increments 0..PERIOD-1.
    - pwm_out=1 exactly in cycles with cnt < active mag, so mag 0 gives always low and mag PERIOD gives always high.
    - period_start=1 when cnt==0.
    - At cnt==PERIOD-1 -> transfer edge.
  - DEAD: pwm_out=0; period_start=0; dead counter runs 0..DEADTIME-1.
    - On its final cycle: dir_out <= new sign, then enter RUN with cnt=0 on the next cycle.
- Transfer edge:
  - Active mag and sat_flag are updated from the transfer source.
  - If new mag != 0 and new sign != dir_out: go to DEAD.
  - Otherwise: go to RUN with cnt=0. This is the next period's first cycle (period_start=1).
  - mag == 0 never changes dir_out.
- Outputs are registers computed from next-state values, so pwm_out and period_start align with cnt in the same cycle with no combinational glitches.
- enable deasserted in RUN or DEAD: next cycle is IDLE, pwm_out=0, cnt and dead counter cleared. A partial dead time does not update dir_out.
- Re-enable from IDLE: behaves as a transfer edge; the dead-time rule applies.
- Reset asserted mid-period or mid-DEAD: outputs go to 0 immediately (async). After release, behaviour is identical to power-up.
- The full 16-bit signed duty_in range is legal; no overflow is possible.

Test Plan (PERIOD=10, MAX_DUTY=10, DEADTIME=3):
- Reset, then enable=1 with duty_in=+4 strobed in the enable cycle -> period_start high at cnt=0; pwm_out high 4 cycles, low 6, repeating; dir_out=0; sat_flag=0.
- In RUN, strobe +7 at cnt=3 -> current period keeps 4 high cycles; next period has 7 high. Strobe +2 exactly at cnt=9 -> the next period uses 2 (bypass).
- duty_in=+500 -> 10 high cycles per period (pwm_out constantly 1); sat_flag=1 from that period start. Repeat with duty_in=-32768 -> magnitude clamps; dir_out=1 after dead time.
- Running at +4, strobe -6 -> at the boundary: 3 DEAD cycles with pwm_out=0 and period_start=0; dir_out flips to 1 on the DEAD exit edge; then 6 high / 4 low.
- Running at +4, strobe 0, then -0 -> pwm_out stays low, dir_out stays 0, no DEAD entered.
- Drop enable mid-DEAD (cycle 2), then re-raise -> IDLE with dir_out unchanged; re-enable performs a full 3-cycle DEAD before RUN. Assert reset mid-period -> pwm_out, dir_out, period_start and sat_flag are 0 immediately.

Source files
------------

// File: rtl/pwm_actuator_if.sv
// pwm_actuator_if: command and drive bundle between the PID stage and the
// H-bridge PWM actuator.
//   enable       run request (low forces IDLE)
//   duty_in      16-bit two's-complement control word
//   duty_valid   single-cycle strobe sampling duty_in
//   pwm_out      registered PWM drive
//   dir_out      registered direction (1 = negative duty)
//   period_start high in the first RUN cycle of each period
//   sat_flag     high while the active magnitude is clamped
// master = controller side, slave = actuator side.
interface pwm_actuator_if;
   logic        enable;
   logic [15:0] duty_in;
   logic        duty_valid;
   logic        pwm_out;
   logic        dir_out;
   logic        period_start;
   logic        sat_flag;

   modport master (
      output enable, duty_in, duty_valid,
      input  pwm_out, dir_out, period_start, sat_flag
   );

   modport slave (
      input  enable, duty_in, duty_valid,
      output pwm_out, dir_out, period_start, sat_flag
   );
endinterface

// File: rtl/pwm_actuator.sv
// pwm_actuator: converts a signed PID control word into sign/magnitude PWM
// drive for an H-bridge. The control word is double-buffered (pending ->
// active at period boundaries), clamped to MAX_DUTY, and a dead-time gap is
// inserted whenever the drive direction reverses.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    pwm_actuator_if.slave (enable, duty_in, duty_valid in;
//          pwm_out, dir_out, period_start, sat_flag out)
module pwm_actuator #(
   parameter int unsigned PERIOD   = 1000,
   parameter int unsigned MAX_DUTY = 1000,
   parameter int unsigned DEADTIME = 16
) (
   input  logic          clk,
   input  logic          reset,
   pwm_actuator_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;

   localparam logic [15:0] CNT_LAST  = 16'(PERIOD - 1);
   localparam logic [15:0] DEAD_LAST = 16'(DEADTIME - 1);
   localparam logic [16:0] MAX_MAG   = 17'(MAX_DUTY);

   logic [1:0]  state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [15:0] dead_cnt, dead_n;

   logic        pend_sign;
   logic [15:0] pend_mag;
   logic        pend_sat;

   logic        act_sign, sign_n;
   logic [15:0] act_mag, mag_n;
   logic        sat_q, sat_n;
   logic        dir_q, dir_n;
   logic        pwm_q;
   logic        ps_q;

   // Sampled-word conversion
   logic [16:0] raw_mag;
   logic        in_sign;
   logic [15:0] in_mag;
   logic        in_sat;

   // Transfer source (bypass when a strobe coincides with the boundary)
   logic        src_sign;
   logic [15:0] src_mag;
   logic        src_sat;
   logic        transfer;

   always_comb begin
      in_sign = bus.duty_in[15];
      // 17-bit negate of the sign-extended word so -32768 yields 32768
      raw_mag = in_sign ? (17'd0 - {1'b1, bus.duty_in}) : {1'b0, bus.duty_in};
      in_sat  = (raw_mag > MAX_MAG);
      in_mag  = in_sat ? MAX_MAG[15:0] : raw_mag[15:0];
   end

   always_comb begin
      src_sign = bus.duty_valid ? in_sign : pend_sign;
      src_mag  = bus.duty_valid ? in_mag  : pend_mag;
      src_sat  = bus.duty_valid ? in_sat  : pend_sat;
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      dead_n   = dead_cnt;
      sign_n   = act_sign;
      mag_n    = act_mag;
      sat_n    = sat_q;
      dir_n    = dir_q;
      transfer = 1'b0;

      if (!bus.enable) begin
         // Partial dead time is abandoned without touching dir_out
         state_n = S_IDLE;
         cnt_n   = '0;
         dead_n  = '0;
      end else begin
         case (state)
            S_IDLE: transfer = 1'b1;
            S_RUN: begin
               if (cnt == CNT_LAST) transfer = 1'b1;
               else                 cnt_n = cnt + 16'd1;
            end
            S_DEAD: begin
               if (dead_cnt == DEAD_LAST) begin
                  dir_n   = act_sign;
                  state_n = S_RUN;
                  cnt_n   = '0;
                  dead_n  = '0;
               end else begin
                  dead_n = dead_cnt + 16'd1;
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
               dead_n  = '0;
            end
         endcase
      end

      if (transfer) begin
         sign_n = src_sign;
         mag_n  = src_mag;
         sat_n  = src_sat;
         cnt_n  = '0;
         dead_n = '0;
         // A zero magnitude never reverses the bridge
         if ((src_mag != '0) && (src_sign != dir_q)) state_n = S_DEAD;
         else                                        state_n = S_RUN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         dead_cnt  <= '0;
         pend_sign <= 1'b0;
         pend_mag  <= '0;
         pend_sat  <= 1'b0;
         act_sign  <= 1'b0;
         act_mag   <= '0;
         sat_q     <= 1'b0;
         dir_q     <= 1'b0;
         pwm_q     <= 1'b0;
         ps_q      <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         dead_cnt <= dead_n;
         act_sign <= sign_n;
         act_mag  <= mag_n;
         sat_q    <= sat_n;
         dir_q    <= dir_n;
         if (bus.duty_valid) begin
            pend_sign <= in_sign;
            pend_mag  <= in_mag;
            pend_sat  <= in_sat;
         end
         // Outputs come from next-state values so they line up with cnt
         pwm_q <= (state_n == S_RUN) && (cnt_n < mag_n);
         ps_q  <= (state_n == S_RUN) && (cnt_n == '0);
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.dir_out      = dir_q;
   assign bus.period_start = ps_q;
   assign bus.sat_flag     = sat_q;

endmodule

// File: tb/tb_pwm_actuator.sv
// tb_pwm_actuator: scoreboard bench for pwm_actuator (PERIOD=10,
// MAX_DUTY=10, DEADTIME=3). The reference model plans whole periods (and
// dead gaps) as lists of expected output cycles; a monitor compares the DUT
// outputs each cycle against the queued expectations.
module tb_pwm_actuator;

   localparam int PERIOD   = 10;
   localparam int MAX_DUTY = 10;
   localparam int DEADTIME = 3;

   typedef struct packed {
      logic pwm;
      logic ps;
      logic dir;
      logic sat;
   } out_t;

   logic clk;
   logic reset;

   pwm_actuator_if bus ();

   pwm_actuator #(
      .PERIOD  (PERIOD),
      .MAX_DUTY(MAX_DUTY),
      .DEADTIME(DEADTIME)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   out_t plan[$];
   out_t expq[$];
   int   pend_val;
   logic cur_dir;
   logic cur_sat;
   int   n_vec;
   int   n_err;

   function automatic out_t dut_out();
      out_t o;
      o.pwm = bus.pwm_out;
      o.ps  = bus.period_start;
      o.dir = bus.dir_out;
      o.sat = bus.sat_flag;
      return o;
   endfunction

   // One clock edge of the reference: returns nothing, queues the output
   // expected right after that edge.
   task automatic model_step(input logic en, input logic vld, input int duty);
      out_t e;
      int   v;
      int   mag;
      logic sgn;
      logic sat;
      logic d;
      if (!en) begin
         plan.delete();
         e = '{pwm: 1'b0, ps: 1'b0, dir: cur_dir, sat: cur_sat};
      end else begin
         if (plan.size() == 0) begin
            v   = vld ? duty : pend_val;
            sgn = (v < 0);
            mag = (v < 0) ? -v : v;
            sat = (mag > MAX_DUTY);
            if (sat) mag = MAX_DUTY;
            d = cur_dir;
            if (mag != 0 && sgn != cur_dir) begin
               for (int unsigned i = 0; i < DEADTIME; i++)
                  plan.push_back('{pwm: 1'b0, ps: 1'b0, dir: cur_dir, sat: sat});
               d = sgn;
            end
            for (int i = 0; i < PERIOD; i++)
               plan.push_back('{pwm: (i < mag), ps: (i == 0), dir: d, sat: sat});
         end
         e = plan.pop_front();
      end
      if (vld) pend_val = duty;
      cur_dir = e.dir;
      cur_sat = e.sat;
      expq.push_back(e);
   endtask

   task automatic cycle(input logic en, input logic vld, input int duty);
      @(negedge clk);
      #1;
      bus.enable     = en;
      bus.duty_valid = vld;
      bus.duty_in    = 16'(duty);
      model_step(en, vld, duty);
   endtask

   task automatic run_to_boundary();
      int guard;
      guard = 0;
      while (plan.size() != 0 && guard < 100) begin
         cycle(1'b1, 1'b0, int'($urandom_range(0, 60)) - 30);
         guard++;
      end
   endtask

   task automatic do_reset(input int unsigned hold);
      out_t got;
      @(negedge clk);
      #1;
      reset          = 1'b1;
      bus.enable     = 1'b0;
      bus.duty_valid = 1'b0;
      #1;
      got = dut_out();
      n_vec++;
      if (got !== 4'b0000) begin
         n_err++;
         $display("FAIL async_reset t=%0t got pwm/ps/dir/sat=%b required=0000", $time, got);
      end
      plan.delete();
      pend_val = 0;
      cur_dir  = 1'b0;
      cur_sat  = 1'b0;
      expq.push_back('0);
      for (int unsigned i = 1; i < hold; i++) begin
         @(negedge clk);
         #1;
         expq.push_back('0);
      end
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: one comparison per queued cycle
   always @(negedge clk) begin
      out_t e;
      out_t got;
      if (expq.size() > 0) begin
         e   = expq.pop_front();
         got = dut_out();
         n_vec++;
         if (got !== e) begin
            n_err++;
            $display("FAIL outputs t=%0t got pwm/ps/dir/sat=%b required=%b", $time, got, e);
         end
      end
   end

   initial begin
      int   v;
      logic [15:0] r;
      n_vec          = 0;
      n_err          = 0;
      pend_val       = 0;
      cur_dir        = 1'b0;
      cur_sat        = 1'b0;
      reset          = 1'b0;
      bus.enable     = 1'b0;
      bus.duty_valid = 1'b0;
      bus.duty_in    = '0;

      do_reset(3);

      // +4 strobed in the enable cycle, then mid-period update to +7
      cycle(1'b1, 1'b1, 4);
      repeat (12) cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b1, 7);
      run_to_boundary();
      run_to_boundary();
      // Bypass: strobe +2 on the boundary edge itself
      cycle(1'b1, 1'b1, 2);
      run_to_boundary();

      // Saturation, then full negative scale with direction change
      cycle(1'b1, 1'b1, 500);
      run_to_boundary();
      run_to_boundary();
      cycle(1'b1, 1'b1, -32768);
      run_to_boundary();
      run_to_boundary();
      run_to_boundary();

      // Back to +4, then reverse to -6
      cycle(1'b1, 1'b1, 4);
      run_to_boundary();
      run_to_boundary();
      run_to_boundary();
      cycle(1'b1, 1'b1, -6);
      run_to_boundary();
      run_to_boundary();
      run_to_boundary();

      // Back to +4, then zero and negative zero: no dead time
      cycle(1'b1, 1'b1, 4);
      run_to_boundary();
      run_to_boundary();
      run_to_boundary();
      cycle(1'b1, 1'b1, 0);
      run_to_boundary();
      run_to_boundary();
      cycle(1'b1, 1'b1, -0);
      run_to_boundary();
      run_to_boundary();

      // Drop enable in the second dead cycle, then re-enable
      cycle(1'b1, 1'b1, 4);
      run_to_boundary();
      run_to_boundary();
      cycle(1'b1, 1'b1, -6);
      run_to_boundary();
      cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b0, 0);
      cycle(1'b0, 1'b0, 0);
      repeat (4) cycle(1'b0, 1'b0, 0);
      cycle(1'b1, 1'b0, 0);
      run_to_boundary();
      run_to_boundary();

      // Reset mid-period while saturated and reversed
      cycle(1'b1, 1'b1, -900);
      run_to_boundary();
      run_to_boundary();
      repeat (4) cycle(1'b1, 1'b0, 0);
      do_reset(2);
      cycle(1'b1, 1'b1, 3);
      run_to_boundary();

      // Randomized phase
      for (int unsigned k = 0; k < 600; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset(2);
         end else begin
            if ($urandom_range(0, 1) == 0) begin
               v = int'($urandom_range(0, 30)) - 15;
            end else begin
               r = 16'($urandom);
               v = int'($signed(r));
            end
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0), v);
         end
      end

      // Drain outstanding expectations within a bounded window
      repeat (3) @(negedge clk);
      #2;
      if (expq.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain got %0d pending required 0", expq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
